oam_dma_ctrl: RTL
=================

Name: oam_dma_ctrl

Overview:
- Sprite-DMA bus controller between the 6502 core and the shared system bus.
- A CPU write to the DMA register stalls the CPU through its ready line and takes ownership of the bus.
- While it owns the bus, it copies XFER_LEN bytes from page {data,8'h00} to the OAM data port as alternating read/write cycles.
- When idle, it passes CPU bus signals straight through to the system bus.

Parameters:
- DMA_REG_ADDR, 16'h4014, address whose write triggers a transfer.
- OAM_DATA_ADDR, 16'h2004, destination port written once per byte.
- XFER_LEN, 256, bytes per transfer; legal range 1..256.

Ports:
- clk_ph1  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- cpu_addr  in  16  CPU address bus.
- cpu_dout  in  8  CPU write data.
- cpu_we  in  1  CPU write strobe for the current cycle.
- bus_din  in  8  read data returned from the system bus.
- bus_addr  out  16  system bus address.
- bus_dout  out  8  system bus write data.
- bus_we  out  1  system bus write strobe.
- cpu_rdy  out  1  low = CPU stalled, because the DMA owns the bus.
- dma_busy  out  1  high from the trigger cycle+1 until the transfer completes.

Behaviour:
- Reset values:
  - state IDLE, cpu_rdy=1, dma_busy=0.
  - page=0, idx=0, buf=0.
  - parity=0.
  - bus outputs in pass-through.
- parity: 1-bit register, toggles every clk_ph1 edge while out of reset. An "even cycle" is parity==0.
- Bus mux:
  - In IDLE, bus_addr/bus_dout/bus_we equal cpu_addr/cpu_dout/cpu_we combinationally.
  - In any other state, the DMA drives all three.
- IDLE:
  - Trigger: cpu_we=1 and cpu_addr==DMA_REG_ADDR.
  - On trigger, latch page<=cpu_dout and go to HALT. That CPU write itself passes through to the bus.
  - Any other CPU access passes through with no effect.
- HALT (1 cycle):
  - cpu_rdy=0, dma_busy=1.
  - Bus: bus_addr=cpu_addr, bus_we=0 (dummy read).
  - Next state: READ if the next cycle is even, else ALIGN.
- ALIGN (0 or 1 cycle):
  - Same bus drive as HALT.
  - Next state: READ.
- READ:
  - Always lands on an even cycle.
  - bus_addr={page,idx[7:0]}, bus_we=0.
  - buf<=bus_din at the cycle end.
  - Next state: WRITE.
- WRITE:
  - bus_addr=OAM_DATA_ADDR, bus_dout=buf, bus_we=1.
  - If idx==XFER_LEN-1: idx<=0 and go to IDLE. Otherwise idx<=idx+1 and go to READ.
- cpu_rdy and dma_busy:
  - Both are registered.
  - cpu_rdy=0 and dma_busy=1 for every non-IDLE state.
  - cpu_rdy returns to 1 in the first IDLE cycle after the final WRITE.
- Stall length: 1 + align(0|1) + 2*XFER_LEN cycles, i.e. 513 or 514 for 256 bytes.
- idx: 9-bit counter. The low 8 bits form the source address, so there is no page crossing; the source wraps within the page and never advances page.
- A write to DMA_REG_ADDR while not IDLE is ignored, with no retrigger and no page change.
- Simultaneous trigger and reset: reset wins.
- Reset mid-transfer:
  - Immediate return to IDLE with cpu_rdy=1.
  - No further OAM writes; a partial transfer is not resumed.
- bus_din is sampled only in READ.

Optional Feature:
- OAM_DMA_DONE_PULSE_EN
  - Defined: adds output dma_done (1 bit, reset 0), a registered one-cycle high pulse in the first IDLE cycle after the final WRITE, coincident with cpu_rdy rising.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle traffic:
  - CPU writes 8'h55 to 16'h0200 → bus_we=1, bus_addr=16'h0200, bus_dout=8'h55 same cycle.
  - cpu_rdy stays 1, dma_busy stays 0.
- Trigger on odd-aligned cycle with memory[16'h0300+i]=i^8'hA5:
  - CPU writes 8'h03 to 16'h4014.
  - 256 writes to 16'h2004 with data i^8'hA5 in order.
  - Every READ on an even cycle.
  - cpu_rdy low for exactly 514 cycles.
- Same transfer triggered one cycle later (opposite parity) → no ALIGN cycle; cpu_rdy low for exactly 513 cycles.
- Assert rst after 10 OAM writes → next edge cpu_rdy=1, dma_busy=0, no further 16'h2004 writes; a new trigger to page 8'h04 restarts at idx 0.
- XFER_LEN=4, page 8'hFF, source bytes 8'h11..8'h44 → bus reads 16'hFF00..16'hFF03, four OAM writes 8'h11, 8'h22, 8'h33, 8'h44; stall of 9 or 10 cycles.
- With OAM_DMA_DONE_PULSE_EN: dma_done high for exactly 1 cycle, coincident with cpu_rdy rising; never high during reset or an aborted transfer.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl
//
// Sprite-DMA bus controller sitting between the 6502 core and the shared
// system bus. A CPU write to DMA_REG_ADDR stalls the CPU (cpu_rdy low) and
// hands the bus to this block. The block then copies XFER_LEN bytes from
// page {written_data, 8'h00} to OAM_DATA_ADDR as alternating read/write
// cycles. While idle, CPU bus signals pass straight through to the bus.
//
// Parameters:
//   DMA_REG_ADDR   address whose CPU write starts a transfer
//   OAM_DATA_ADDR  destination port, written once per byte
//   XFER_LEN       bytes per transfer, legal range 1..256
//
// Ports:
//   clk_ph1   in   system clock, all state updates on the rising edge
//   rst       in   asynchronous reset, active-high
//   cpu_addr  in   CPU address bus
//   cpu_dout  in   CPU write data
//   cpu_we    in   CPU write strobe for the current cycle
//   bus_din   in   read data returned from the system bus
//   bus_addr  out  system bus address
//   bus_dout  out  system bus write data
//   bus_we    out  system bus write strobe
//   cpu_rdy   out  low while the DMA owns the bus (CPU stalled)
//   dma_busy  out  high from the cycle after the trigger until completion
//   dma_done  out  (only with OAM_DMA_DONE_PULSE_EN) one-cycle pulse in the
//                  first idle cycle after the final write
//
// Build option:
//   OAM_DMA_DONE_PULSE_EN  when defined, adds the dma_done output.
// ---------------------------------------------------------------------------
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    input  logic [7:0]  bus_din,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_we,
    output logic        cpu_rdy,
    output logic        dma_busy
`ifdef OAM_DMA_DONE_PULSE_EN
    ,
    output logic        dma_done
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } state_e;

    localparam logic [8:0] LAST_IDX = 9'(XFER_LEN - 1);

    state_e      state_q, state_d;
    logic [7:0]  page_q,  page_d;
    logic [8:0]  idx_q,   idx_d;
    logic [7:0]  data_q,  data_d;
    logic        parity_q;
    logic        cpu_rdy_q;
    logic        dma_busy_q;
`ifdef OAM_DMA_DONE_PULSE_EN
    logic        done_q, done_d;
`endif

    logic trigger;
    logic last_byte;

    assign trigger   = cpu_we && (cpu_addr == DMA_REG_ADDR);
    assign last_byte = (idx_q == LAST_IDX);

    // Next-state logic.
    // NOTE: every signal gets its hold value first, so no path through the
    // case can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
`ifdef OAM_DMA_DONE_PULSE_EN
        done_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // Writes to the DMA register are only honoured here, so a
                // write while busy can neither retrigger nor change the page.
                if (trigger) begin
                    page_d  = cpu_dout;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                // parity_q is the current cycle; the next cycle is even
                // exactly when the current one is odd.
                state_d = parity_q ? ST_READ : ST_ALIGN;
            end
            ST_ALIGN: begin
                state_d = ST_READ;
            end
            ST_READ: begin
                data_d  = bus_din;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (last_byte) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
`ifdef OAM_DMA_DONE_PULSE_EN
                    done_d  = 1'b1;
`endif
                end else begin
                    idx_d   = idx_q + 9'd1;
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus ownership mux: transparent when idle, DMA-driven otherwise.
    always_comb begin
        bus_addr = cpu_addr;
        bus_dout = cpu_dout;
        bus_we   = cpu_we;
        case (state_q)
            ST_IDLE: begin
                bus_addr = cpu_addr;
                bus_dout = cpu_dout;
                bus_we   = cpu_we;
            end
            ST_READ: begin
                // Only the low 8 index bits address the source, so the
                // read wraps within the page rather than crossing it.
                bus_addr = {page_q, idx_q[7:0]};
                bus_dout = data_q;
                bus_we   = 1'b0;
            end
            ST_WRITE: begin
                bus_addr = OAM_DATA_ADDR;
                bus_dout = data_q;
                bus_we   = 1'b1;
            end
            default: begin
                // HALT and ALIGN: dummy read at the CPU's current address.
                bus_addr = cpu_addr;
                bus_dout = data_q;
                bus_we   = 1'b0;
            end
        endcase
    end

    // State and registered status outputs. cpu_rdy/dma_busy are derived
    // from the next state so they line up with the state they describe.
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk_ph1 or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            page_q     <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            parity_q   <= 1'b0;
            cpu_rdy_q  <= 1'b1;
            dma_busy_q <= 1'b0;
`ifdef OAM_DMA_DONE_PULSE_EN
            done_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            parity_q   <= ~parity_q;
            cpu_rdy_q  <= (state_d == ST_IDLE);
            dma_busy_q <= (state_d != ST_IDLE);
`ifdef OAM_DMA_DONE_PULSE_EN
            done_q     <= done_d;
`endif
        end
    end

    assign cpu_rdy  = cpu_rdy_q;
    assign dma_busy = dma_busy_q;
`ifdef OAM_DMA_DONE_PULSE_EN
    assign dma_done = done_q;
`endif

endmodule
